// File: rtl/mc_pkg.sv
// Shared types and defaults for the multicycle control sequencer.
package mc_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/multicycle_sequencer_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_instret,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (inc_instret) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Five-phase multicycle sequencer with req/ack memory handshakes and syscall halt.
//
// state  | meaning
// FETCH  | imem_req high until imem_ack; latch instr
// DECODE | decoder settles on the new instr
// EXEC   | pc <= next_pc (unless syscall); pick MEM / WB / FETCH / HALT
// MEM    | dmem_req high until dmem_ack; loads continue to WB
// WB     | one-cycle register-file write strobe
// HALT   | halted after syscall; resume returns to FETCH
module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  instr,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             reg_write,
    input  logic             is_ctrl,
    input  logic             is_syscall,
    input  logic [XLEN-1:0]  next_pc,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    input  logic             resume,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t state;
    logic   inc_instret;
    logic   is_mem;

    assign imem_addr = pc;
    assign is_mem    = is_load | is_store;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instr    <= '0;
            imem_req <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            rf_we    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_syscall) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        pc <= next_pc;
                        if (is_mem) begin
                            dmem_req <= 1'b1;
                            dmem_we  <= is_store;
                            state    <= MEM;
                        end else if (reg_write) begin
                            rf_we <= 1'b1;
                            state <= WB;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                MEM: begin
                    // dmem_we was latched from is_store on entry and marks the access kind
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            rf_we <= 1'b1;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                HALT: begin
                    if (resume) begin
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    imem_req <= 1'b1;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    halted   <= 1'b0;
                    state    <= FETCH;
                end
            endcase
        end
    end

    // Retire on the edge leaving the last state of each instruction.
    always_comb begin
        inc_instret = 1'b0;
        case (state)
            EXEC:    inc_instret = is_syscall | ~(is_mem | reg_write);
            MEM:     inc_instret = dmem_ack & dmem_we;
            WB:      inc_instret = 1'b1;
            default: inc_instret = 1'b0;
        endcase
    end

    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk        (clk),
        .reset      (reset),
        .inc_instret(inc_instret),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    logic unused_ctrl;
    assign unused_ctrl = is_ctrl;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: instructions are expanded into per-cycle expectations and replayed.
module tb_multicycle_sequencer;
    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, halted, resume;
    logic [31:0] imem_addr, imem_rdata, instr, next_pc, pc;
    logic        is_load, is_store, reg_write, is_ctrl, is_syscall;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    multicycle_sequencer #(.XLEN(32), .RESET_PC(32'h100), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .is_load(is_load), .is_store(is_store), .reg_write(reg_write),
        .is_ctrl(is_ctrl), .is_syscall(is_syscall), .next_pc(next_pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .halted(halted), .resume(resume),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ia;
        logic [31:0] ird;
        logic        ld, st, rw, sys, ctl;
        logic [31:0] npc;
        logic        da;
        logic        res;
        logic        e_ireq, e_dreq, e_dwe, e_rfwe, e_halt;
        logic [31:0] e_pc, e_instr;
        logic [CW-1:0] e_cyc, e_ret;
    } cyc_t;

    cyc_t q[$];
    logic [31:0]   m_pc, m_instr;
    logic [CW-1:0] m_cyc, m_ret;
    int checks = 0, errors = 0;
    int s_ireq, s_dreq, s_rfwe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c.ia = 1'($urandom); c.ird = $urandom;
        c.ld = 1'($urandom); c.st = 1'($urandom); c.rw = 1'($urandom);
        c.sys = 1'($urandom); c.ctl = 1'($urandom);
        c.npc = $urandom; c.da = 1'($urandom); c.res = ($urandom_range(0, 3) == 0);
        c.e_ireq = 1'b0; c.e_dreq = 1'b0; c.e_dwe = 1'b0; c.e_rfwe = 1'b0; c.e_halt = 1'b0;
        c.e_pc = '0; c.e_instr = '0; c.e_cyc = '0; c.e_ret = '0;
        return c;
    endfunction

    task automatic push(input cyc_t c);
        c.e_pc = m_pc; c.e_instr = m_instr; c.e_cyc = m_cyc; c.e_ret = m_ret;
        q.push_back(c);
        m_cyc++;
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 branch (no writeback), 4 syscall
    task automatic gen(input int kind, input int iw, input int dw,
                       input logic [31:0] tgt, input int hl);
        cyc_t c;
        logic ld, st, rw, sys;
        logic [31:0] word;
        word = $urandom; ld = 0; st = 0; rw = 0; sys = 0;
        case (kind)
            0: rw = 1;
            1: begin ld = 1; rw = 1; end
            2: begin st = 1; rw = 1'($urandom); end
            3: ;
            default: begin sys = 1; ld = 1'($urandom); st = 1'($urandom); rw = 1'($urandom); end
        endcase
        for (int i = 0; i <= iw; i++) begin
            c = blank(); c.e_ireq = 1; c.ia = (i == iw);
            if (i == iw) c.ird = word;
            push(c);
        end
        m_instr = word;
        c = blank(); c.ld = ld; c.st = st; c.rw = rw; c.sys = sys; push(c);
        c = blank(); c.ld = ld; c.st = st; c.rw = rw; c.sys = sys; c.npc = tgt; push(c);
        if (sys) begin
            m_ret++;
            for (int h = 0; h <= hl; h++) begin
                c = blank(); c.e_halt = 1; c.res = (h == hl); push(c);
            end
        end else begin
            m_pc = tgt;
            if (ld || st) begin
                for (int j = 0; j <= dw; j++) begin
                    c = blank(); c.ld = ld; c.st = st; c.rw = rw; c.sys = 0;
                    c.e_dreq = 1; c.e_dwe = st; c.da = (j == dw);
                    push(c);
                end
                if (st) m_ret++;
            end
            if (!st && rw) begin
                c = blank(); c.ld = ld; c.st = st; c.rw = rw; c.sys = 0;
                c.e_rfwe = 1; push(c);
                m_ret++;
            end else if (!st && !ld) begin
                m_ret++;
            end
        end
    endtask

    task automatic run_one();
        cyc_t c;
        c = q.pop_front();
        chk("imem_req", 32'(imem_req), 32'(c.e_ireq));
        chk("imem_addr", imem_addr, c.e_pc);
        chk("pc", pc, c.e_pc);
        chk("instr", instr, c.e_instr);
        chk("dmem_req", 32'(dmem_req), 32'(c.e_dreq));
        chk("dmem_we", 32'(dmem_we), 32'(c.e_dwe));
        chk("rf_we", 32'(rf_we), 32'(c.e_rfwe));
        chk("halted", 32'(halted), 32'(c.e_halt));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(c.e_cyc));
        chk("instret_cnt", 32'(instret_cnt), 32'(c.e_ret));
        s_ireq += 32'(imem_req); s_dreq += 32'(dmem_req); s_rfwe += 32'(rf_we);
        imem_ack = c.ia; imem_rdata = c.ird; is_load = c.ld; is_store = c.st;
        reg_write = c.rw; is_syscall = c.sys; is_ctrl = c.ctl; next_pc = c.npc;
        dmem_ack = c.da; resume = c.res;
        @(posedge clk);
        #1;
    endtask

    task automatic run_all();
        while (q.size() > 0) run_one();
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 32'h100; m_instr = '0; m_cyc = '0; m_ret = '0;
    endtask

    initial begin
        logic [CW-1:0] r0;
        reset = 1'b0; imem_ack = 0; imem_rdata = '0; is_load = 0; is_store = 0;
        reg_write = 0; is_ctrl = 0; is_syscall = 0; next_pc = '0; dmem_ack = 0; resume = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // ALU, zero wait
        gen(0, 0, 0, 32'h104, 0);
        chk("lit_addr_c1", imem_addr, 32'h100);
        chk("lit_instr_rst", instr, 32'h0);
        run_one(); run_one(); run_one();
        chk("lit_rfwe_c4", 32'(rf_we), 32'd1);
        chk("lit_pc_c4", pc, 32'h104);
        run_one();
        chk("lit_instret_1", 32'(instret_cnt), 32'd1);

        // load with imem wait 2, dmem wait 3
        r0 = instret_cnt; s_ireq = 0; s_dreq = 0; s_rfwe = 0;
        gen(1, 2, 3, m_pc + 32'd4, 0);
        for (int i = 0; i < 9; i++) run_one();
        chk("load_not_retired_9", 32'(instret_cnt), 32'(r0));
        run_one();
        chk("load_retired_10", 32'(instret_cnt), 32'(r0 + 8'd1));
        chk("load_ireq_cycles", 32'(s_ireq), 32'd3);
        chk("load_dreq_cycles", 32'(s_dreq), 32'd4);
        chk("load_rfwe_pulses", 32'(s_rfwe), 32'd1);

        // store then branch to 0x200
        r0 = instret_cnt; s_rfwe = 0;
        gen(2, 0, 0, m_pc + 32'd4, 0);
        gen(3, 0, 0, 32'h200, 0);
        run_all();
        chk("sb_next_fetch", imem_addr, 32'h200);
        chk("sb_instret", 32'(instret_cnt), 32'(r0 + 8'd2));
        chk("sb_no_rfwe", 32'(s_rfwe), 32'd0);

        // syscall, halt 22 cycles then resume
        gen(4, 0, 0, 32'hdead_beec, 21);
        run_one(); run_one(); run_one();
        chk("lit_halted_c4", 32'(halted), 32'd1);
        run_all();
        chk("resume_fetch_pc", imem_addr, 32'h200);
        chk("resume_req", 32'(imem_req), 32'd1);

        // reset during a MEM wait
        gen(1, 0, 5, m_pc + 32'd4, 0);
        for (int i = 0; i < 5; i++) run_one();
        chk("pre_rst_dreq", 32'(dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_dreq", 32'(dmem_req), 32'd0);
        chk("rst_ireq", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_cycle", 32'(cycle_cnt), 32'd0);
        chk("rst_instret", 32'(instret_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // 256 ALU instructions wrap instret
        r0 = instret_cnt;
        for (int i = 0; i < 256; i++) gen(0, 0, 0, m_pc + 32'd4, 0);
        run_all();
        chk("instret_wrap", 32'(instret_cnt), 32'(r0));

        // random mix
        for (int i = 0; i < 80; i++) begin
            int k;
            logic [31:0] t;
            k = $urandom_range(0, 9);
            k = (k >= 8) ? 4 : k % 4;
            t = ($urandom_range(0, 1) == 0) ? m_pc + 32'd4 : ($urandom & 32'hffff_fffc);
            gen(k, $urandom_range(0, 3), $urandom_range(0, 3), t, $urandom_range(0, 4));
            run_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
